// File: rtl/seq_divider_28by14_if.sv
// Start/busy/valid handshake and operand/result bus between a controller and the
// sequential divider.
interface seq_divider_28by14_if #(
    parameter int unsigned DIVIDEND_W = 28,
    parameter int unsigned DIVISOR_W  = 14
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  valid;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_28by14.sv
// Iterative restoring divider: one quotient bit per clock, ripple-borrow subtractor,
// start/busy/valid handshake. Results are held until the next completion or reset.
module seq_divider_28by14 #(
    parameter int unsigned DIVIDEND_W = 28,
    parameter int unsigned DIVISOR_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_divider_28by14_if.slave   bus
);
    localparam int unsigned    CntW     = $clog2(DIVIDEND_W);
    localparam logic [CntW-1:0] LastIter = CntW'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [CntW-1:0]       r_cnt;
    // P never exceeds divisor-1 after an iteration, so its top bit is always zero.
    logic [DIVISOR_W-1:0]  r_p;
    logic [DIVIDEND_W-1:0] r_d;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    logic [DIVISOR_W:0]    w_t;
    logic [DIVISOR_W-1:0]  w_diff;
    logic [DIVISOR_W-1:0]  w_nb;
    logic [DIVISOR_W-1:0]  w_p_next;
    logic                  w_no_borrow;
    logic                  w_accept;

    assign w_t  = {r_p, r_d[DIVIDEND_W-1]};
    assign w_nb = ~r_divisor;

    // T + ~{0,divisor} + 1 via full adders; the MSB stage adds a constant 1, so
    // its carry reduces to t_msb | carry_in.
    always_comb begin : ripple_sub
        logic carry;
        carry  = 1'b1;
        w_diff = '0;
        for (int i = 0; i < int'(DIVISOR_W); i++) begin
            w_diff[i] = w_t[i] ^ w_nb[i] ^ carry;
            carry     = (w_t[i] & w_nb[i]) | (carry & (w_t[i] ^ w_nb[i]));
        end
        w_no_borrow = w_t[DIVISOR_W] | carry;
    end

    assign w_p_next = w_no_borrow ? w_diff : w_t[DIVISOR_W-1:0];
    assign w_accept = bus.start && (r_state != StCalc);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_state_next = (bus.divisor == '0) ? StDone : StCalc;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StCalc: begin
                if (r_cnt == LastIter) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_p         <= '0;
            r_d         <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt     <= '0;
                r_p       <= '0;
                r_q       <= '0;
                r_d       <= bus.dividend;
                r_divisor <= bus.divisor;
                if (bus.divisor == '0) begin
                    r_quotient  <= '1;
                    r_remainder <= '0;
                    r_dbz       <= 1'b1;
                end
            end else if (r_state == StCalc) begin
                r_cnt <= r_cnt + 1'b1;
                r_p   <= w_p_next;
                r_d   <= {r_d[DIVIDEND_W-2:0], 1'b0};
                r_q   <= {r_q[DIVIDEND_W-2:0], w_no_borrow};
                if (r_cnt == LastIter) begin
                    r_quotient  <= {r_q[DIVIDEND_W-2:0], w_no_borrow};
                    r_remainder <= w_p_next;
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = (r_state == StCalc);
    assign bus.valid       = (r_state == StDone);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider_28by14.sv
// Self-checking bench for seq_divider_28by14: directed cases, back-to-back
// throughput, reset abort and a randomized sweep against plain integer division.
module tb_seq_divider_28by14;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    logic [27:0] prev_q;
    logic [13:0] prev_r;

    always #5 clk = ~clk;

    seq_divider_28by14_if #(.DIVIDEND_W(28), .DIVISOR_W(14)) bus ();

    seq_divider_28by14 #(.DIVIDEND_W(28), .DIVISOR_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [27:0] dvd, input logic [13:0] dvs,
                         output logic [27:0] q, output logic [13:0] r, output logic dbz);
        if (dvs == 14'd0) begin
            q = 28'hFFFFFFF; r = 14'd0; dbz = 1'b1;
        end else begin
            q = dvd / 28'(dvs); r = 14'(dvd % 28'(dvs)); dbz = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input logic [27:0] dvd, input logic [13:0] dvs);
        logic [27:0] eq;
        logic [13:0] er;
        logic        ez;
        model(dvd, dvs, eq, er, ez);
        check({tag, "_quotient"}, 64'(bus.quotient), 64'(eq));
        check({tag, "_remainder"}, 64'(bus.remainder), 64'(er));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ez));
        if (dvs != 14'd0) begin
            check({tag, "_identity"},
                  64'(bus.quotient) * 64'(dvs) + 64'(bus.remainder), 64'(dvd));
            check({tag, "_rem_lt_div"}, 64'(bus.remainder < dvs), 64'd1);
        end
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_valid"}, 64'(bus.valid), 64'd0);
        check({tag, "_quotient"}, 64'(bus.quotient), 64'd0);
        check({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    // One operation: accept, scramble operands and pulse start mid-computation, then
    // check latency, busy length, held outputs, results and the single-cycle valid.
    task automatic run_op(input string tag, input logic [27:0] dvd, input logic [13:0] dvs);
        int cyc;
        int busy_cyc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 28'($urandom);
        bus.divisor  = 14'($urandom);
        cyc      = 1;
        busy_cyc = 0;
        while (!bus.valid && cyc < 64) begin
            if (bus.busy) busy_cyc++;
            if (cyc == 5) begin
                check({tag, "_hold_q"}, 64'(bus.quotient), 64'(prev_q));
                check({tag, "_hold_r"}, 64'(bus.remainder), 64'(prev_r));
            end
            bus.start = (cyc == 10);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, "_valid_seen"}, 64'(bus.valid), 64'd1);
        check({tag, "_latency"}, 64'(cyc), (dvs == 14'd0) ? 64'd1 : 64'd29);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), (dvs == 14'd0) ? 64'd0 : 64'd28);
        check_result(tag, dvd, dvs);
        @(negedge clk);
        check({tag, "_valid_pulse"}, 64'(bus.valid), 64'd0);
    endtask

    initial begin
        logic [27:0] pair_dvd [4];
        logic [13:0] pair_dvs [4];
        logic [27:0] dvd;
        logic [13:0] dvs;
        int          cyc;
        int          n_valid;

        pair_dvd = '{28'd1000000, 28'd5, 28'd268435455, 28'd777};
        pair_dvs = '{14'd1234, 14'd9, 14'd16383, 14'd1};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b1;
        prev_q       = '0;
        prev_r       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        run_op("basic", 28'd1000000, 14'd1234);
        run_op("max", 28'd268435455, 14'd16383);
        run_op("small", 28'd5, 14'd9);
        run_op("dbz", 28'd12345, 14'd0);
        run_op("div1", 28'd12345, 14'd1);

        // Back-to-back with start held high; operands scrambled after each accept.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = pair_dvd[0];
        bus.divisor  = pair_dvs[0];
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 28'($urandom);
        bus.divisor  = 14'($urandom);
        for (int k = 0; k < 4; k++) begin
            cyc = 1;
            while (!bus.valid && cyc < 64) begin
                @(negedge clk);
                cyc++;
            end
            check("b2b_valid_seen", 64'(bus.valid), 64'd1);
            check("b2b_period", 64'(cyc), 64'd29);
            check_result("b2b", pair_dvd[k], pair_dvs[k]);
            if (k < 3) begin
                bus.dividend = pair_dvd[k+1];
                bus.divisor  = pair_dvs[k+1];
                @(posedge clk);
                @(negedge clk);
                bus.dividend = 28'($urandom);
                bus.divisor  = 14'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);

        // Reset in the middle of a computation.
        bus.start    = 1'b1;
        bus.dividend = 28'd1000000;
        bus.divisor  = 14'd1234;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("abort");
        reset   = 1'b0;
        prev_q  = '0;
        prev_r  = '0;
        n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid) n_valid++;
        end
        check("abort_no_valid", 64'(n_valid), 64'd0);
        run_op("after_abort", 28'd1000000, 14'd1234);

        // Randomized sweep with edge-case operands mixed in.
        for (int i = 0; i < 1200; i++) begin
            dvd = 28'($urandom);
            dvs = 14'($urandom);
            case (i % 8)
                0: dvs = 14'd1;
                1: dvs = 14'd16383;
                2: dvd = 28'd0;
                3: dvd = 28'hFFFFFFF;
                default: ;
            endcase
            run_op("rand", dvd, dvs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
